// File: rtl/shift_arb.sv
// shift_arb: one registered 32-bit shift/rotate datapath shared by two requesters.
//
// Each requester raises req with op/value/shcnt and holds them until it sees ack.
// Requests are sampled only while idle; the granted operands are latched, the
// shifter evaluates them in the following cycle and the result lands in that
// requester's res register, with a one-cycle ack pulse in the cycle after that.
// One operation is in flight at a time (3 cycles per operation).
//
// Parameters:
//   FAIR      1 = round-robin when both request, 0 = r0 always wins
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-high
//   rN_req_i     requester N operation request
//   rN_op_i      00=lsl 01=lsr 10=asr 11=ror
//   rN_value_i   operand to shift
//   rN_shcnt_i   shift/rotate count 0..31
//   rN_ack_o     one-cycle pulse: rN operation complete, rN_res_o valid
//   rN_res_o     last result delivered to requester N (held)
//   busy_o       high while an operation is executing or completing
module shift_arb #(
  parameter int unsigned FAIR = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        r0_req_i,
  input  logic [1:0]  r0_op_i,
  input  logic [31:0] r0_value_i,
  input  logic [4:0]  r0_shcnt_i,
  output logic        r0_ack_o,
  output logic [31:0] r0_res_o,
  input  logic        r1_req_i,
  input  logic [1:0]  r1_op_i,
  input  logic [31:0] r1_value_i,
  input  logic [4:0]  r1_shcnt_i,
  output logic        r1_ack_o,
  output logic [31:0] r1_res_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e      state_q;
  logic [1:0]  op_q;
  logic [31:0] value_q;
  logic [4:0]  shcnt_q;
  logic        owner_q;       // 0 = r0, 1 = r1
  logic        last_grant_q;  // owner of the most recent grant
  logic [31:0] r0_res_q, r1_res_q;
  logic        r0_ack_q, r1_ack_q;
  logic        busy_q;

  logic        grant_valid;
  logic        grant_owner;
  logic [31:0] shift_res;
  logic [63:0] rot_wide;

  // Arbitration between the two requesters, only acted on in StIdle.
  always_comb begin
    grant_valid = r0_req_i | r1_req_i;
    grant_owner = 1'b0;
    if (r0_req_i && r1_req_i) begin
      grant_owner = (FAIR != 0) ? ~last_grant_q : 1'b0;
    end else begin
      grant_owner = r1_req_i;
    end
  end

  // Shifter works from the latched operands only.
  always_comb begin
    // Rotate right as a funnel shift of the operand concatenated with itself.
    rot_wide  = {value_q, value_q} >> shcnt_q;
    shift_res = value_q;
    case (op_q)
      2'b00:   shift_res = value_q << shcnt_q;
      2'b01:   shift_res = value_q >> shcnt_q;
      2'b10:   shift_res = $unsigned($signed(value_q) >>> shcnt_q);
      default: shift_res = rot_wide[31:0];
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      op_q         <= 2'b00;
      value_q      <= 32'd0;
      shcnt_q      <= 5'd0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;  // r0 wins the first contest
      r0_res_q     <= 32'd0;
      r1_res_q     <= 32'd0;
      r0_ack_q     <= 1'b0;
      r1_ack_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          r0_ack_q <= 1'b0;
          r1_ack_q <= 1'b0;
          if (grant_valid) begin
            op_q         <= grant_owner ? r1_op_i    : r0_op_i;
            value_q      <= grant_owner ? r1_value_i : r0_value_i;
            shcnt_q      <= grant_owner ? r1_shcnt_i : r0_shcnt_i;
            owner_q      <= grant_owner;
            last_grant_q <= grant_owner;
            busy_q       <= 1'b1;
            state_q      <= StExec;
          end
        end
        StExec: begin
          if (owner_q) begin
            r1_res_q <= shift_res;
            r1_ack_q <= 1'b1;
          end else begin
            r0_res_q <= shift_res;
            r0_ack_q <= 1'b1;
          end
          busy_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          r0_ack_q <= 1'b0;
          r1_ack_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          r0_ack_q <= 1'b0;
          r1_ack_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign r0_ack_o = r0_ack_q;
  assign r1_ack_o = r1_ack_q;
  assign r0_res_o = r0_res_q;
  assign r1_res_o = r1_res_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_shift_arb.sv
// tb_shift_arb: table-driven directed checks, hand-written arbitration/reset
// sequences, and a randomized run against a transaction-level reference model.
module tb_shift_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req [2];
  logic [1:0]  op  [2];
  logic [31:0] val [2];
  logic [4:0]  cnt [2];
  logic        ack [2];
  logic [31:0] res [2];
  logic        busy;
  logic        fp_ack [2];
  logic [31:0] fp_res [2];
  logic        fp_busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_res [2];

  always #5 clk = ~clk;

  shift_arb #(.FAIR(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .r0_req_i(req[0]), .r0_op_i(op[0]), .r0_value_i(val[0]), .r0_shcnt_i(cnt[0]),
    .r0_ack_o(ack[0]), .r0_res_o(res[0]),
    .r1_req_i(req[1]), .r1_op_i(op[1]), .r1_value_i(val[1]), .r1_shcnt_i(cnt[1]),
    .r1_ack_o(ack[1]), .r1_res_o(res[1]),
    .busy_o(busy)
  );

  shift_arb #(.FAIR(0)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .r0_req_i(req[0]), .r0_op_i(op[0]), .r0_value_i(val[0]), .r0_shcnt_i(cnt[0]),
    .r0_ack_o(fp_ack[0]), .r0_res_o(fp_res[0]),
    .r1_req_i(req[1]), .r1_op_i(op[1]), .r1_value_i(val[1]), .r1_shcnt_i(cnt[1]),
    .r1_ack_o(fp_ack[1]), .r1_res_o(fp_res[1]),
    .busy_o(fp_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference shift from arithmetic definitions: multiply/divide by 2**c, bit-index rotate.
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] v,
                                            input logic [4:0] c);
    logic [63:0] pow, wide;
    logic [31:0] r, nv;
    pow = 64'd1;
    for (int j = 0; j < int'(c); j++) pow = pow * 64'd2;
    r = 32'd0;
    case (o)
      2'b00: begin wide = {32'd0, v} * pow; r = wide[31:0]; end
      2'b01: begin wide = {32'd0, v} / pow; r = wide[31:0]; end
      2'b10: begin
        if (v[31]) begin
          nv = ~v;
          wide = {32'd0, nv} / pow;
          r = ~wide[31:0];
        end else begin
          wide = {32'd0, v} / pow;
          r = wide[31:0];
        end
      end
      default: for (int i = 0; i < 32; i++) r[i] = v[(i + int'(c)) % 32];
    endcase
    return r;
  endfunction

  // Single operation from an idle DUT; called at a negedge (cycle n).
  task automatic run_op(input int rq, input logic [1:0] o, input logic [31:0] v,
                        input logic [4:0] c, input logic [31:0] e, input string nm);
    req[rq] = 1'b1; op[rq] = o; val[rq] = v; cnt[rq] = c;
    @(negedge clk);  // n+1
    check($sformatf("%s ack@n+1", nm), ack[rq], 1'b0);
    check($sformatf("%s busy@n+1", nm), busy, 1'b1);
    // Changes after the grant edge must not affect the result.
    op[rq] = ~o; val[rq] = ~v; cnt[rq] = c + 5'd1;
    @(negedge clk);  // n+2
    check($sformatf("%s ack@n+2", nm), ack[rq], 1'b1);
    check($sformatf("%s other ack", nm), ack[1-rq], 1'b0);
    check($sformatf("%s res", nm), res[rq], e);
    check($sformatf("%s other res", nm), res[1-rq], exp_res[1-rq]);
    check($sformatf("%s busy@n+2", nm), busy, 1'b1);
    exp_res[rq] = e;
    req[rq] = 1'b0;
    @(negedge clk);  // n+3
    check($sformatf("%s ack@n+3", nm), ack[rq], 1'b0);
    check($sformatf("%s busy@n+3", nm), busy, 1'b0);
    check($sformatf("%s res held", nm), res[rq], e);
  endtask

  typedef struct {
    int          rq;
    logic [1:0]  op;
    logic [31:0] val;
    logic [4:0]  cnt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  // Random-phase model state
  int          m_phase;  // cycles since grant: 0 idle, 1 executing, 2 completing
  int          m_owner;
  int          m_last;
  logic [31:0] m_pend;
  logic [31:0] m_res [2];
  bit          active [2];

  task automatic new_operands(input int i);
    op[i]  = 2'($urandom_range(3, 0));
    cnt[i] = 5'($urandom_range(31, 0));
    case ($urandom_range(5, 0))
      0:       val[i] = 32'h8000_0000;
      1:       val[i] = 32'hFFFF_FFFF;
      default: val[i] = $urandom;
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; op[i] = 2'b00; val[i] = 32'd0; cnt[i] = 5'd0; exp_res[i] = 32'd0;
    end
    vecs[0]  = '{0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[1]  = '{1, 2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000};
    vecs[2]  = '{1, 2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000};
    vecs[3]  = '{1, 2'b11, 32'h0000_000F, 5'd4,  32'hF000_0000};
    vecs[4]  = '{0, 2'b00, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[5]  = '{0, 2'b01, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[6]  = '{1, 2'b10, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[7]  = '{1, 2'b11, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vecs[8]  = '{0, 2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456};
    vecs[9]  = '{1, 2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    vecs[10] = '{0, 2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001};
    vecs[11] = '{1, 2'b00, 32'h1234_5678, 5'd4,  32'h2345_6780};

    // Reset held with requests toggling: everything stays quiet.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req[0] = ~req[0];
      req[1] = 1'($urandom_range(1, 0));
      #1;
      check($sformatf("rst c%0d ack0", c), ack[0], 1'b0);
      check($sformatf("rst c%0d ack1", c), ack[1], 1'b0);
      check($sformatf("rst c%0d res0", c), res[0], 32'd0);
      check($sformatf("rst c%0d res1", c), res[1], 32'd0);
      check($sformatf("rst c%0d busy", c), busy, 1'b0);
    end
    @(negedge clk);
    req[0] = 1'b0; req[1] = 1'b0; rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 12; t++) begin
      run_op(vecs[t].rq, vecs[t].op, vecs[t].val, vecs[t].cnt, vecs[t].exp,
             $sformatf("vec%0d", t));
    end

    // Both held from reset: round-robin alternates, fixed priority starves r1.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req[0] = 1'b1; op[0] = 2'b00; val[0] = 32'h1; cnt[0] = 5'd1;
    req[1] = 1'b1; op[1] = 2'b11; val[1] = 32'h1; cnt[1] = 5'd1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check($sformatf("rr n+%0d ack0", i), ack[0], (i == 2 || i == 8) ? 1'b1 : 1'b0);
      check($sformatf("rr n+%0d ack1", i), ack[1], (i == 5 || i == 11) ? 1'b1 : 1'b0);
      check($sformatf("fp n+%0d ack0", i), fp_ack[0], (i % 3 == 2) ? 1'b1 : 1'b0);
      check($sformatf("fp n+%0d ack1", i), fp_ack[1], 1'b0);
      check($sformatf("fp n+%0d busy", i), fp_busy, (i % 3 != 0) ? 1'b1 : 1'b0);
    end
    req[0] = 1'b0; req[1] = 1'b0;
    check("rr res0", res[0], 32'h0000_0002);
    check("rr res1", res[1], 32'h8000_0000);
    check("fp res0", fp_res[0], 32'h0000_0002);
    check("fp res1", fp_res[1], 32'h0000_0000);
    @(negedge clk);

    // Reset pulsed while an r1 operation is executing.
    req[1] = 1'b1; op[1] = 2'b10; val[1] = 32'h8000_0000; cnt[1] = 5'd4;
    @(negedge clk);  // executing
    rst = 1'b1;
    #1;
    check("midrst busy", busy, 1'b0);
    check("midrst ack1", ack[1], 1'b0);
    check("midrst res1", res[1], 32'd0);
    check("midrst res0", res[0], 32'd0);
    @(negedge clk);
    rst = 1'b0; req[1] = 1'b0;
    exp_res[0] = 32'd0; exp_res[1] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("postrst c%0d ack1", i), ack[1], 1'b0);
      check($sformatf("postrst c%0d busy", i), busy, 1'b0);
    end
    run_op(1, 2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000, "postrst r1");

    // Randomized traffic against the reference model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_phase = 0; m_owner = 0; m_last = 1; m_pend = 32'd0;
    m_res[0] = 32'd0; m_res[1] = 32'd0;
    active[0] = 1'b0; active[1] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("rand c%0d ack%0d", cyc, i), ack[i],
              (m_phase == 2 && m_owner == i) ? 1'b1 : 1'b0);
        check($sformatf("rand c%0d res%0d", cyc, i), res[i], m_res[i]);
      end
      check($sformatf("rand c%0d busy", cyc), busy, (m_phase != 0) ? 1'b1 : 1'b0);
      // Requesters obey the handshake: hold until ack, then drop or issue another.
      for (int i = 0; i < 2; i++) begin
        if (active[i]) begin
          if (m_phase == 2 && m_owner == i) begin
            if ($urandom_range(1, 0) == 0) active[i] = 1'b0;
            else new_operands(i);
          end
        end else if ($urandom_range(9, 0) < 4) begin
          active[i] = 1'b1;
          new_operands(i);
        end
        req[i] = active[i];
      end
      // Advance the model across the coming rising edge.
      if (m_phase == 0) begin
        if (req[0] || req[1]) begin
          if (req[0] && req[1]) m_owner = 1 - m_last;
          else m_owner = req[1] ? 1 : 0;
          m_last  = m_owner;
          m_pend  = ref_shift(op[m_owner], val[m_owner], cnt[m_owner]);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_res[m_owner] = m_pend;
        m_phase = 2;
      end else begin
        m_phase = 0;
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
